ffstdp_update_pipe: RTL and testbench
=====================================

// Module: ffstdp_update_pipe
// PURPOSE
//  Multi-lane, pipelined successor of the single-synapse FF-STDP update datapath. Per beat it takes NUM_LANES synapses
//  (weight, gradient, pre/post spike trains) read from synapse SRAM, computes the goodness-weighted FF-STDP
//  derivative, then accumulates gradient or applies it to weight with saturation. Results return with the SRAM
//  address tag for write-back. Sits between the synaptic SRAM read port and its write port, stallable by write-back.
// PARAMETERS
//  NUM_LANES     4   synapses processed per beat
//  T_STEPS       8   spike-train length (bits per lane in PRE/POST)
//  WEIGHT_WIDTH  8   signed weight width
//  GRAD_WIDTH    8   signed gradient width
//  GOOD_WIDTH    12  unsigned AVG_GOODNESS width
//  GOOD_FRAC     10  fractional bits of AVG_GOODNESS; ONE = 1<<GOOD_FRAC
//  LR_SHIFT      2   learning-rate right shift after product
//  ADDR_WIDTH    10  SRAM address tag width
// PORTS
//  CLK          in   1                       clock
//  RST_N        in   1                       asynchronous active-low reset
//  IN_VALID     in   1                       input beat valid
//  IN_READY     out  1                       block accepts beat
//  IN_ADDR      in   ADDR_WIDTH              SRAM address tag
//  MODE         in   2                       00 pass, 01 accumulate, 10 apply, 11 clear-grad
//  IS_POS       in   1                       positive (1) / negative (0) phase
//  AVG_GOODNESS in   GOOD_WIDTH              average layer goodness, Q(GOOD_FRAC)
//  PRE_SPIKES   in   NUM_LANES*T_STEPS       per-lane pre spike trains, lane i at [i*T_STEPS +: T_STEPS]
//  POST_SPIKES  in   NUM_LANES*T_STEPS       per-lane post spike trains, same packing
//  WSYN_CURR    in   NUM_LANES*WEIGHT_WIDTH  current weights, lane-packed
//  GRAD_CURR    in   NUM_LANES*GRAD_WIDTH    current gradients, lane-packed
//  OUT_VALID    out  1                       result beat valid
//  OUT_READY    in   1                       write-back accepts result
//  OUT_ADDR     out  ADDR_WIDTH              tag of result beat
//  WSYN_NEW     out  NUM_LANES*WEIGHT_WIDTH  new weights
//  GRAD_NEW     out  NUM_LANES*GRAD_WIDTH    new gradients
//  SAT_FLAGS    out  NUM_LANES               lane saturated (grad or weight) in this beat
//  SAT_CNT      out  16                      only with FFSTDP_SAT_CNT_EN
// BEHAVIOUR
//  - Reset: all stage valids 0; OUT_VALID=0, OUT_ADDR=0, WSYN_NEW=0, GRAD_NEW=0, SAT_FLAGS=0, SAT_CNT=0.
//  - 3-stage pipe S1/S2/S3; adv = !OUT_VALID | OUT_READY; IN_READY = adv; all stages shift only when adv.
//  - Accept on IN_VALID&IN_READY; result OUT_VALID exactly 3 cycles later if never stalled; stall freezes all
//    stages and outputs stable while OUT_VALID&!OUT_READY. Bubbles propagate as valid=0, no beat dropped/duplicated.
//  - S1: register inputs; G = min(AVG_GOODNESS, ONE); sum_i = popcount(PRE_i & POST_i), width clog2(T_STEPS)+1.
//  - S2: coef = IS_POS ? G : ONE-G; mag_i = (sum_i*coef) >> (GOOD_FRAC+LR_SHIFT), full precision;
//    d_i = IS_POS ? +mag_i : -mag_i (truncation toward zero); d_i saturated to GRAD_WIDTH signed range.
//  - S3 per MODE: 00 W=WSYN_CURR, G=GRAD_CURR; 01 G=sat(GRAD_CURR+d), W unchanged;
//    10 W=sat(WSYN_CURR+GRAD_CURR), G=0 (d ignored); 11 W unchanged, G=0.
//  - sat(): clamp to [-2^(N-1), 2^(N-1)-1] of target width, computed with one extra bit; SAT_FLAGS[i]=1 iff clamp hit.
//  - GRAD_WIDTH > WEIGHT_WIDTH: apply sign-extends weight to GRAD_WIDTH+1 before clamp to weight range.
//  - Reset mid-operation: in-flight beats discarded, no OUT_VALID issued for them.
//  - IN_VALID while !IN_READY: beat not taken; source must hold it.
// CONFIGURATION
//  FFSTDP_SAT_CNT_EN defined: SAT_CNT adds popcount(SAT_FLAGS) on each OUT_VALID&OUT_READY handshake, saturates
//  at 16'hFFFF, cleared only by reset. Undefined: SAT_CNT port absent, no counter logic.
// TESTING
//  1 MODE=01, IS_POS=1, G=1024, PRE=POST=8'hFF all lanes, GRAD=0 -> after 3 cycles GRAD_NEW=2 each lane, WSYN unchanged.
//  2 MODE=01, IS_POS=0, G=0, PRE=POST=8'hFF, GRAD=-127 -> GRAD_NEW=-128 (d=-2 clamped), SAT_FLAGS=4'hF.
//  3 MODE=10, W=-128, GRAD=-5 lane0; W=10, GRAD=3 lane1 -> WSYN_NEW=-128 / 13, GRAD_NEW=0, SAT_FLAGS[0]=1 only.
//  4 G=2000 (>ONE), IS_POS=1, sum=8 -> treated as G=1024, d=2; G=512, sum=4 -> d=0 (truncated).
//  5 10 back-to-back beats, OUT_READY low cycles 4-7 -> IN_READY low while stalled, 10 in-order results, tags match.
//  6 RST_N low with 2 beats in flight -> OUT_VALID stays 0, all outputs 0; next beat after release has latency 3.

Source files
------------

// File: rtl/ffstdp_update_pipe.sv
// Multi-lane, 3-stage FF-STDP synapse update pipe between synaptic SRAM read and write-back.
// Optional saturation counter output sat_cnt_o is built when FFSTDP_SAT_CNT_EN is defined.
module ffstdp_update_pipe #(
  parameter int NUM_LANES    = 4,
  parameter int T_STEPS      = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int GRAD_WIDTH   = 8,
  parameter int GOOD_WIDTH   = 12,
  parameter int GOOD_FRAC    = 10,
  parameter int LR_SHIFT     = 2,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [ADDR_WIDTH-1:0]             in_addr_i,
  input  logic [1:0]                        mode_i,
  input  logic                              is_pos_i,
  input  logic [GOOD_WIDTH-1:0]             avg_goodness_i,
  input  logic [NUM_LANES*T_STEPS-1:0]      pre_spikes_i,
  input  logic [NUM_LANES*T_STEPS-1:0]      post_spikes_i,
  input  logic [NUM_LANES*WEIGHT_WIDTH-1:0] wsyn_curr_i,
  input  logic [NUM_LANES*GRAD_WIDTH-1:0]   grad_curr_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [ADDR_WIDTH-1:0]             out_addr_o,
  output logic [NUM_LANES*WEIGHT_WIDTH-1:0] wsyn_new_o,
  output logic [NUM_LANES*GRAD_WIDTH-1:0]   grad_new_o,
  output logic [NUM_LANES-1:0]              sat_flags_o
`ifdef FFSTDP_SAT_CNT_EN
  ,output logic [15:0]                      sat_cnt_o
`endif
);

  localparam int ONE = 1 << GOOD_FRAC;
  localparam int SW  = $clog2(T_STEPS) + 1;
  localparam int CW  = GOOD_FRAC + 1;
  localparam int PW  = SW + CW;
  localparam int SH  = GOOD_FRAC + LR_SHIFT;
  localparam int DW  = (PW + 2 > GRAD_WIDTH + 1) ? PW + 2 : GRAD_WIDTH + 1;
  localparam int WW  = WEIGHT_WIDTH;
  localparam int GW  = GRAD_WIDTH;
  localparam int MW  = (WW > GW) ? WW : GW;
  localparam int NW  = NUM_LANES * WW;
  localparam int NG  = NUM_LANES * GW;

  localparam logic signed [DW-1:0] D_MAX = DW'((1 << (GW - 1)) - 1);
  localparam logic signed [DW-1:0] D_MIN = ~D_MAX;
  localparam logic signed [GW:0]   G_MAX = (GW + 1)'((1 << (GW - 1)) - 1);
  localparam logic signed [GW:0]   G_MIN = ~G_MAX;
  localparam logic signed [MW:0]   W_MAX = (MW + 1)'((1 << (WW - 1)) - 1);
  localparam logic signed [MW:0]   W_MIN = ~W_MAX;

  // Valid/ready: a beat moves on a cycle where valid and ready are both high; every stage
  // advances together when the output register is empty or being drained, otherwise all hold.
  logic adv;
  assign adv        = !out_valid_o | out_ready_i;
  assign in_ready_o = adv;

  logic [CW-1:0]           g_clip;
  logic [NUM_LANES*SW-1:0] sum_d;
  logic [NG-1:0]           d_d;
  logic [NUM_LANES-1:0]    dsat_d;
  logic [NW-1:0]           wsyn_d;
  logic [NG-1:0]           grad_d;
  logic [NUM_LANES-1:0]    flags_d;

  logic                    v1_q, pos1_q;
  logic [ADDR_WIDTH-1:0]   addr1_q;
  logic [1:0]              mode1_q;
  logic [CW-1:0]           g1_q;
  logic [NUM_LANES*SW-1:0] sum1_q;
  logic [NW-1:0]           w1_q;
  logic [NG-1:0]           gr1_q;

  logic                    v2_q;
  logic [ADDR_WIDTH-1:0]   addr2_q;
  logic [1:0]              mode2_q;
  logic [NW-1:0]           w2_q;
  logic [NG-1:0]           gr2_q;
  logic [NG-1:0]           d2_q;
  logic [NUM_LANES-1:0]    dsat2_q;

  always_comb begin
    if (32'(avg_goodness_i) > ONE) g_clip = CW'(ONE);
    else                           g_clip = CW'(avg_goodness_i);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [CW-1:0]          coef;
    logic [PW-1:0]          prod;
    logic signed [DW-1:0]   dv;
    logic signed [GW-1:0]   d_c;
    logic                   dsat_c;
    logic signed [WW-1:0]   wi, wn;
    logic signed [GW-1:0]   gi, di, gn;
    logic signed [GW:0]     gsum;
    logic signed [MW:0]     wsum;
    logic                   fl;

    assign sum_d[i*SW +: SW] = SW'($countones(pre_spikes_i[i*T_STEPS +: T_STEPS] &
                                              post_spikes_i[i*T_STEPS +: T_STEPS]));
    assign coef = pos1_q ? g1_q : CW'(ONE) - g1_q;
    assign prod = PW'(sum1_q[i*SW +: SW]) * PW'(coef);

    // Magnitude is truncated before the sign is applied, so negative updates round toward zero.
    always_comb begin
      dv     = pos1_q ? $signed(DW'(prod >> SH)) : -$signed(DW'(prod >> SH));
      dsat_c = 1'b0;
      if (dv > D_MAX) begin
        d_c = D_MAX[GW-1:0]; dsat_c = 1'b1;
      end else if (dv < D_MIN) begin
        d_c = D_MIN[GW-1:0]; dsat_c = 1'b1;
      end else begin
        d_c = dv[GW-1:0];
      end
    end
    assign d_d[i*GW +: GW] = d_c;
    assign dsat_d[i]       = dsat_c;

    assign wi   = w2_q[i*WW +: WW];
    assign gi   = gr2_q[i*GW +: GW];
    assign di   = d2_q[i*GW +: GW];
    assign gsum = (GW + 1)'(gi) + (GW + 1)'(di);
    assign wsum = (MW + 1)'(wi) + (MW + 1)'(gi);

    always_comb begin
      wn = wi;
      gn = gi;
      fl = 1'b0;
      case (mode2_q)
        2'b01: begin
          if (gsum > G_MAX)      begin gn = G_MAX[GW-1:0]; fl = 1'b1; end
          else if (gsum < G_MIN) begin gn = G_MIN[GW-1:0]; fl = 1'b1; end
          else                         gn = gsum[GW-1:0];
          fl = fl | dsat2_q[i];
        end
        2'b10: begin
          gn = '0;
          if (wsum > W_MAX)      begin wn = W_MAX[WW-1:0]; fl = 1'b1; end
          else if (wsum < W_MIN) begin wn = W_MIN[WW-1:0]; fl = 1'b1; end
          else                         wn = wsum[WW-1:0];
        end
        2'b11:   gn = '0;
        default: ;
      endcase
    end
    assign wsyn_d[i*WW +: WW] = wn;
    assign grad_d[i*GW +: GW] = gn;
    assign flags_d[i]         = fl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; pos1_q <= 1'b0; addr1_q <= '0; mode1_q <= '0;
      g1_q <= '0; sum1_q <= '0; w1_q <= '0; gr1_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        pos1_q  <= is_pos_i;
        addr1_q <= in_addr_i;
        mode1_q <= mode_i;
        g1_q    <= g_clip;
        sum1_q  <= sum_d;
        w1_q    <= wsyn_curr_i;
        gr1_q   <= grad_curr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; addr2_q <= '0; mode2_q <= '0;
      w2_q <= '0; gr2_q <= '0; d2_q <= '0; dsat2_q <= '0;
    end else if (adv) begin
      v2_q <= v1_q;
      if (v1_q) begin
        addr2_q <= addr1_q;
        mode2_q <= mode1_q;
        w2_q    <= w1_q;
        gr2_q   <= gr1_q;
        d2_q    <= d_d;
        dsat2_q <= dsat_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0; out_addr_o <= '0;
      wsyn_new_o  <= '0;   grad_new_o <= '0; sat_flags_o <= '0;
    end else if (adv) begin
      out_valid_o <= v2_q;
      if (v2_q) begin
        out_addr_o  <= addr2_q;
        wsyn_new_o  <= wsyn_d;
        grad_new_o  <= grad_d;
        sat_flags_o <= flags_d;
      end
    end
  end

`ifdef FFSTDP_SAT_CNT_EN
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, sat_cnt_o} + 17'($countones(sat_flags_o));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         sat_cnt_o <= '0;
    else if (out_valid_o & out_ready_i) sat_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_ffstdp_update_pipe.sv
// Bench for ffstdp_update_pipe: directed cases, randomized beats with random back-pressure,
// a stall burst and mid-flight reset, all scored against an arithmetic model of the update rule.
module tb_ffstdp_update_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, is_pos, out_valid, out_ready;
  logic [9:0]  in_addr, out_addr;
  logic [1:0]  mode;
  logic [11:0] avg_goodness;
  logic [31:0] pre_spikes, post_spikes, wsyn_curr, grad_curr, wsyn_new, grad_new;
  logic [3:0]  sat_flags;
`ifdef FFSTDP_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  ffstdp_update_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .mode_i(mode), .is_pos_i(is_pos), .avg_goodness_i(avg_goodness),
    .pre_spikes_i(pre_spikes), .post_spikes_i(post_spikes),
    .wsyn_curr_i(wsyn_curr), .grad_curr_i(grad_curr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
    .wsyn_new_o(wsyn_new), .grad_new_o(grad_new), .sat_flags_o(sat_flags)
`ifdef FFSTDP_SAT_CNT_EN
    , .sat_cnt_o(sat_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          stall_seen = 0;
  logic [77:0] exp_q[$];
  logic [77:0] e;
  logic [77:0] prev_out;
  logic        prev_stall = 1'b0;
  logic        done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected beat {addr, wsyn, grad, flags} from the update rule in plain integer arithmetic.
  function automatic logic [77:0] model(input logic [9:0] addr, input logic [1:0] md,
                                        input logic pos, input logic [11:0] avg,
                                        input logic [31:0] pre, input logic [31:0] post,
                                        input logic [31:0] w, input logic [31:0] g);
    int gg, coef, sum, mag, d, wi, gi, nw, ng;
    logic [31:0] wo, go;
    logic [3:0]  f;
    wo = '0; go = '0; f = '0;
    gg = (avg > 12'd1024) ? 1024 : int'(avg);
    coef = pos ? gg : 1024 - gg;
    for (int l = 0; l < 4; l++) begin
      sum = $countones(pre[8*l +: 8] & post[8*l +: 8]);
      mag = (sum * coef) / 4096;
      d   = pos ? mag : -mag;
      wi  = int'($signed(w[8*l +: 8]));
      gi  = int'($signed(g[8*l +: 8]));
      nw  = wi;
      ng  = gi;
      case (md)
        2'd1: ng = gi + d;
        2'd2: begin nw = wi + gi; ng = 0; end
        2'd3: ng = 0;
        default: ;
      endcase
      if (nw > 127)       begin nw = 127;  f[l] = 1'b1; end
      else if (nw < -128) begin nw = -128; f[l] = 1'b1; end
      if (ng > 127)       begin ng = 127;  f[l] = 1'b1; end
      else if (ng < -128) begin ng = -128; f[l] = 1'b1; end
      wo[8*l +: 8] = nw[7:0];
      go[8*l +: 8] = ng[7:0];
    end
    return {addr, wo, go, f};
  endfunction

  // Presents one beat, holds it until taken (bounded), records its expected result.
  task automatic drive_beat(input logic [9:0] addr, input logic [1:0] md, input logic pos,
                            input logic [11:0] avg, input logic [31:0] pre, input logic [31:0] post,
                            input logic [31:0] w, input logic [31:0] g);
    int   k;
    logic acc;
    k = 0; acc = 1'b0;
    in_addr = addr; mode = md; is_pos = pos; avg_goodness = avg;
    pre_spikes = pre; post_spikes = post; wsyn_curr = w; grad_curr = g;
    in_valid = 1'b1;
    while (!acc && k < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(addr, md, pos, avg, pre, post, w, g));
        acc = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
  endtask

  // Single beat into an empty pipe: checks 3-cycle latency and the given constant results.
  task automatic send_check(input string tag, input logic [1:0] md, input logic pos,
                            input logic [11:0] avg, input logic [31:0] pre, input logic [31:0] post,
                            input logic [31:0] w, input logic [31:0] g,
                            input logic [31:0] ew, input logic [31:0] eg, input logic [3:0] ef);
    drive_beat(10'h155, md, pos, avg, pre, post, w, g);
    @(negedge clk); check_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk); check_eq({tag, "_lat2"}, 64'(out_valid), 64'd0);
    @(negedge clk); check_eq({tag, "_lat3"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_wsyn"}, 64'(wsyn_new), 64'(ew));
    check_eq({tag, "_grad"}, 64'(grad_new), 64'(eg));
    check_eq({tag, "_flags"}, 64'(sat_flags), 64'(ef));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_hold_data", {wsyn_new, grad_new}, prev_out[67:4]);
        check_eq("stall_hold_tag", 64'({out_addr, sat_flags}), 64'({prev_out[77:68], prev_out[3:0]}));
      end
      if (out_valid && !out_ready) begin
        stall_seen++;
        check_eq("in_ready_stall", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_out", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_addr", 64'(out_addr), 64'(e[77:68]));
          check_eq("sb_wsyn", 64'(wsyn_new), 64'(e[67:36]));
          check_eq("sb_grad", 64'(grad_new), 64'(e[35:4]));
          check_eq("sb_flags", 64'(sat_flags), 64'(e[3:0]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_addr, wsyn_new, grad_new, sat_flags};
    end
  end

  initial begin
    in_valid = 1'b0; in_addr = '0; mode = '0; is_pos = 1'b0; avg_goodness = '0;
    pre_spikes = '0; post_spikes = '0; wsyn_curr = '0; grad_curr = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_addr", 64'(out_addr), 64'd0);
    check_eq("rst_wsyn", 64'(wsyn_new), 64'd0);
    check_eq("rst_grad", 64'(grad_new), 64'd0);
    check_eq("rst_flags", 64'(sat_flags), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);

    send_check("t1", 2'd1, 1'b1, 12'd1024, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11223344, 32'h0,
               32'h11223344, 32'h02020202, 4'h0);
    send_check("t2", 2'd1, 1'b0, 12'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h81818181,
               32'h0, 32'h80808080, 4'hF);
    send_check("t3", 2'd2, 1'b1, 12'd700, 32'h5A5A5A5A, 32'hFFFF0000, 32'h00000A80, 32'h000003FB,
               32'h00000D80, 32'h0, 4'h1);
    send_check("t4a", 2'd1, 1'b1, 12'd2000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
               32'h0, 32'h02020202, 4'h0);
    send_check("t4b", 2'd1, 1'b1, 12'd512, 32'hFF0F0F0F, 32'hFF0F0F0F, 32'h0, 32'h0,
               32'h0, 32'h01000000, 4'h0);
    send_check("t4c", 2'd1, 1'b0, 12'd0, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0, 32'h0,
               32'h0, 32'hFFFFFFFF, 4'h0);
    send_check("pass", 2'd0, 1'b1, 12'd1024, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h807F0102, 32'h7F80FE01,
               32'h807F0102, 32'h7F80FE01, 4'h0);
    send_check("clr", 2'd3, 1'b1, 12'd1024, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h807F0102, 32'h7F80FE01,
               32'h807F0102, 32'h0, 4'h0);

    // Random beats with random gaps and random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          drive_beat(10'($urandom), 2'($urandom), 1'($urandom), 12'($urandom_range(0, 2047)),
                     ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom,
                     $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'h7F7F8081 : $urandom);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");

    // Ten back-to-back beats with write-back stalled for four cycles.
    stall_seen = 0;
    fork
      begin
        for (int n = 0; n < 10; n++)
          drive_beat(10'(100 + n), 2'($urandom), 1'($urandom), 12'($urandom_range(0, 1500)),
                     $urandom, $urandom, $urandom, $urandom);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("burst_drain");
    check_eq("burst_stall_seen", 64'(stall_seen != 0), 64'd1);

    // Reset with beats in flight: they must vanish.
    drive_beat(10'h3A0, 2'd1, 1'b1, 12'd1024, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01010101, 32'h01010101);
    drive_beat(10'h3A1, 2'd2, 1'b1, 12'd1024, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01010101, 32'h01010101);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_data", {wsyn_new, grad_new}, 64'd0);
    check_eq("mid_rst_tag", 64'({out_addr, sat_flags}), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send_check("post_rst", 2'd1, 1'b1, 12'd1024, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h05060708, 32'h7E000000,
               32'h05060708, 32'h7F020202, 4'h8);
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
